mpy_pipe_ctrl: RTL

- Pipelined issue/writeback controller for the SPU even-pipe 16x16 fixed-point multiply datapath.
- Accepts one multiply instruction per cycle and computes four 32-bit word lanes in parallel.
- Carries the result and target-register tag through a fixed-latency pipeline, then presents it for register-file writeback.
- Also reports in-flight destination registers to the issue logic for RAW hazard detection, and supports pipeline stall and flush.

---
 rtl/spu_mpy_pkg.sv | 34 +++
 rtl/mpy_lane.sv | 43 ++++
 rtl/mpy_pipe_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/spu_mpy_pkg.sv
// Shared types for the SPU even-pipe 16x16 multiply controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package spu_mpy_pkg;

    // Multiply flavours; unused encodings do not exist in a 2-bit field.
    typedef enum logic [1:0] {
        MPY  = 2'd0,
        MPYU = 2'd1,
        MPYH = 2'd2,
        MPYA = 2'd3
    } mpy_op_t;

    localparam int LANES    = 4;
    localparam int QW       = 128;
    localparam int LANE_W   = QW / LANES;

    // Stage records carry the destination tag at this width.
    // Register-file address widths up to this value are supported.
    localparam int RT_W_MAX = 8;

    // One pipeline stage: valid flag, destination tag, result quadword.
    typedef struct packed {
        logic                valid;
        logic [RT_W_MAX-1:0] rt;
        logic [QW-1:0]       data;
    } pipe_stage_t;

    // Sign-extend a 16-bit halfword to a full lane.
    function automatic logic [LANE_W-1:0] sext16(input logic [15:0] x);
        return {{(LANE_W-16){x[15]}}, x};
    endfunction

endpackage

// File: rtl/mpy_lane.sv
// One 32-bit lane of the 16x16 multiplier: MPY, MPYU, MPYH, MPYA.
// Latency: purely combinational; registered by the controller's stage 1.
// Backpressure: none; the controller decides when the result is captured.
module mpy_lane
    import spu_mpy_pkg::*;
(
    input  mpy_op_t           i_op,
    input  logic [LANE_W-1:0] i_ra,
    input  logic [LANE_W-1:0] i_rb,
    input  logic [LANE_W-1:0] i_rc,
    output logic [LANE_W-1:0] o_res
);

    logic [LANE_W-1:0] w_sprod;
    logic [LANE_W-1:0] w_uprod;
    logic [15:0]       w_hprod;
    logic              w_unused_rb_hi;

    // The low 32 bits of a product of sign-extended halfwords equal the
    // signed 16x16 product, so an unsigned 32-bit multiply suffices.
    assign w_sprod = sext16(i_ra[15:0]) * sext16(i_rb[15:0]);
    assign w_uprod = {16'h0000, i_ra[15:0]} * {16'h0000, i_rb[15:0]};

    // MPYH keeps only the low half of hi(RA)*lo(RB) after the shift by 16,
    // so only a 16-bit product is needed.
    assign w_hprod = i_ra[31:16] * i_rb[15:0];

    // hi(RB) is never an operand of any flavour.
    assign w_unused_rb_hi = &{1'b0, i_rb[31:16]};

    // Select the lane result by opcode; anything unexpected behaves as MPY.
    always_comb begin
        o_res = w_sprod;
        case (i_op)
            MPY:     o_res = w_sprod;
            MPYU:    o_res = w_uprod;
            MPYH:    o_res = {w_hprod, 16'h0000};
            MPYA:    o_res = w_sprod + i_rc;
            default: o_res = w_sprod;
        endcase
    end

endmodule

// File: rtl/mpy_pipe_ctrl.sv
// Issue/writeback controller for the 4-lane 16x16 multiply pipe with RAW hazard probe.
// Latency: result presented LATENCY cycles after the issue cycle when not stalled.
// Backpressure: global stall when out_valid && !out_ready; in_ready follows it, flush wins over issue.
module mpy_pipe_ctrl
    import spu_mpy_pkg::*;
#(
    parameter int LATENCY = 7,
    parameter int RF_AW   = 7
)(
    input  logic             clk,
    input  logic             reset,

    input  logic             in_valid,
    output logic             in_ready,
    input  mpy_op_t          in_op,
    input  logic [QW-1:0]    in_ra,
    input  logic [QW-1:0]    in_rb,
    input  logic [QW-1:0]    in_rc,
    input  logic [RF_AW-1:0] in_rt,

    input  logic             flush,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [RF_AW-1:0] out_rt,
    output logic [QW-1:0]    out_data,

    input  logic [RF_AW-1:0] chk_rt,
    output logic             chk_hit,
    output logic             busy
);

    // Stage 1 is the multiplier output register, stage LATENCY drives out_*.
    pipe_stage_t r_stage [1:LATENCY];

    logic [QW-1:0]       w_result;
    logic                w_advance;
    logic [RT_W_MAX-1:0] w_in_rt;
    logic [RT_W_MAX-1:0] w_chk_rt;
    logic                w_hit;
    logic                w_busy;

    // Four independent lanes feed stage 1.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mpy_lane u_lane (
            .i_op  (in_op),
            .i_ra  (in_ra[LANE_W*g +: LANE_W]),
            .i_rb  (in_rb[LANE_W*g +: LANE_W]),
            .i_rc  (in_rc[LANE_W*g +: LANE_W]),
            .o_res (w_result[LANE_W*g +: LANE_W])
        );
    end

    // The whole pipe moves only when the writeback slot is empty or draining.
    assign w_advance = !r_stage[LATENCY].valid || out_ready;
    assign in_ready  = w_advance;

    // Tags are held zero-extended so the hazard compare is one width.
    assign w_in_rt  = RT_W_MAX'(in_rt);
    assign w_chk_rt = RT_W_MAX'(chk_rt);

    // Stage array: flush clears every valid bit (stalled or not), otherwise
    // shift on advance and hold everything, bubbles included, on stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 1; i <= LATENCY; i++) begin
                r_stage[i].valid <= 1'b0;
            end
        end else if (w_advance) begin
            r_stage[1].valid <= in_valid;
            r_stage[1].rt    <= w_in_rt;
            r_stage[1].data  <= w_result;
            for (int i = 2; i <= LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // Hazard probe and occupancy across every stage, the output stage included.
    always_comb begin
        w_hit  = 1'b0;
        w_busy = 1'b0;
        for (int i = 1; i <= LATENCY; i++) begin
            if (r_stage[i].valid) begin
                w_busy = 1'b1;
                if (r_stage[i].rt == w_chk_rt) begin
                    w_hit = 1'b1;
                end
            end
        end
    end

    assign chk_hit   = w_hit;
    assign busy      = w_busy;

    assign out_valid = r_stage[LATENCY].valid;
    assign out_rt    = r_stage[LATENCY].rt[RF_AW-1:0];
    assign out_data  = r_stage[LATENCY].data;

endmodule
